// File: rtl/ram_pkg.sv
// Shared encodings for the MFA/MFC byte-addressed memory responder.
package ram_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Request fields latched when ramMFA is accepted.
  typedef struct packed {
    logic              rw;
    logic [1:0]        size;
    logic [DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/ram_mfc_responder_if.sv
// Memory handshake bundle between the control unit (master) and the RAM (slave).
interface ram_mfc_responder_if
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
);

  logic              ramMFA;
  logic              ramRW;
  logic [1:0]        ramDataSize;
  logic [ADDR_W-1:0] ramAddress;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataOut;
  logic              ramMFC;
  logic              ramErr;

  modport master (
    output ramMFA, ramRW, ramDataSize, ramAddress, dataIn,
    input  dataOut, ramMFC, ramErr
  );

  modport slave (
    input  ramMFA, ramRW, ramDataSize, ramAddress, dataIn,
    output dataOut, ramMFC, ramErr
  );

endinterface

// File: rtl/ram_lane_steer.sv
// Big-endian lane steering: lane i is the byte at address base+i.
// Produces lane enables, alignment flag, write bytes and zero-extended read data.
module ram_lane_steer
  import ram_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0][7:0]   rd_bytes,
  output logic [3:0]        lane_en,
  output logic              aligned,
  output logic [3:0][7:0]   wr_bytes,
  output logic [DATA_W-1:0] rdata
);

  always_comb begin
    lane_en  = 4'b1111;
    aligned  = (addr_lo == 2'b00);
    wr_bytes = '0;
    rdata    = {rd_bytes[0], rd_bytes[1], rd_bytes[2], rd_bytes[3]};
    wr_bytes[0] = wdata[31:24];
    wr_bytes[1] = wdata[23:16];
    wr_bytes[2] = wdata[15:8];
    wr_bytes[3] = wdata[7:0];
    case (size)
      SIZE_BYTE: begin
        lane_en     = 4'b0001;
        aligned     = 1'b1;
        wr_bytes    = '0;
        wr_bytes[0] = wdata[7:0];
        rdata       = {24'h0, rd_bytes[0]};
      end
      SIZE_HALF: begin
        lane_en     = 4'b0011;
        aligned     = ~addr_lo[0];
        wr_bytes    = '0;
        wr_bytes[0] = wdata[15:8];
        wr_bytes[1] = wdata[7:0];
        rdata       = {16'h0, rd_bytes[0], rd_bytes[1]};
      end
      default: ;  // word, and reserved 2'b10 treated as word
    endcase
  end

endmodule

// File: rtl/ram_mfc_responder.sv
// Byte-addressed big-endian RAM answering the MFA/MFC handshake after LATENCY wait cycles.
// Optional `RAM_ALIGN_CHECK_EN: misaligned accesses are suppressed and flagged on ramErr.
module ram_mfc_responder
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned LATENCY = 2
) (
  input logic                 Clk,
  input logic                 reset,
  ram_mfc_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  logic [7:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, acc;
  logic [ADDR_W-1:0] addr_q, acc_addr, base;
  logic              mfc_q;
  logic [DATA_W-1:0] dout_q;
  logic              capture_c, commit_c, wr_en_c, rd_en_c;

  logic [3:0][7:0]   rd_bytes, wr_bytes;
  logic [3:0]        lane_en;
  logic              aligned;
  logic [DATA_W-1:0] rdata;

  // Zero-latency commits straight from IDLE, so the live bus is the access source there.
  always_comb begin
    acc      = req_q;
    acc_addr = addr_q;
    if (state_q == IDLE) begin
      acc.rw   = bus.ramRW;
      acc.size = bus.ramDataSize;
      acc.data = bus.dataIn;
      acc_addr = bus.ramAddress;
    end
  end

  always_comb begin
    base = acc_addr;
`ifndef RAM_ALIGN_CHECK_EN
    case (acc.size)
      SIZE_BYTE: base = acc_addr;
      SIZE_HALF: base = {acc_addr[ADDR_W-1:1], 1'b0};
      default:   base = {acc_addr[ADDR_W-1:2], 2'b00};
    endcase
`endif
  end

  always_comb begin
    rd_bytes = '0;
    for (int i = 0; i < 4; i++) begin
      rd_bytes[i] = mem[base + ADDR_W'(i)];
    end
  end

  ram_lane_steer u_steer (
    .size     (acc.size),
    .addr_lo  (base[1:0]),
    .wdata    (acc.data),
    .rd_bytes (rd_bytes),
    .lane_en  (lane_en),
    .aligned  (aligned),
    .wr_bytes (wr_bytes),
    .rdata    (rdata)
  );

  // Next-state logic; the access commits on the edge that enters DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_c = 1'b0;
    commit_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ramMFA) begin
          capture_c = 1'b1;
          if (LATENCY == 0) begin
            state_d  = DONE;
            commit_c = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d  = DONE;
          commit_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (!bus.ramMFA) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en_c = commit_c && aligned && (acc.rw == RW_WRITE);
  assign rd_en_c = commit_c && aligned && (acc.rw == RW_READ);

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      addr_q  <= '0;
      mfc_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mfc_q   <= (state_q == DONE);
      if (capture_c) begin
        req_q  <= acc;
        addr_q <= acc_addr;
      end
      if (rd_en_c) dout_q <= rdata;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en_c && lane_en[i]) mem[base + ADDR_W'(i)] <= wr_bytes[i];
    end
  end

`ifdef RAM_ALIGN_CHECK_EN
  logic mis_q, err_q;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (commit_c) mis_q <= ~aligned;
      err_q <= (state_q == DONE) && mis_q;
    end
  end

  assign bus.ramErr = err_q;
`else
  assign bus.ramErr = 1'b0;
`endif

  assign bus.ramMFC  = mfc_q;
  assign bus.dataOut = dout_q;

endmodule
